// File: rtl/vicii_pkg.sv
// Shared VIC-II constants: default sprite count, colour width, register offsets
// and the colour type used across the sprite datapath.
package vicii_pkg;

  localparam int NSPR_DEF = 8;
  localparam int CW_DEF   = 4;

  localparam logic [5:0] REG_MDP = 6'h1B;
  localparam logic [5:0] REG_MM  = 6'h1E;
  localparam logic [5:0] REG_MD  = 6'h1F;

  typedef logic [CW_DEF-1:0] colour_t;

endpackage

// File: rtl/vicii_collision_latch.sv
// One collision register ($D01E or $D01F): sticky hit accumulation, clear-on-read,
// and a single-clock IRQ request when the register leaves the all-zero state.
module vicii_collision_latch #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic [N-1:0] hit,
  output logic [N-1:0] lat,
  output logic         irq
);

  logic [N-1:0] lat_d, lat_q;
  logic         irq_d, irq_q;

  // A hit arriving with the read is OR-ed in after the clear so it is never lost.
  always_comb begin
    lat_d = (rd ? '0 : lat_q) | hit;
    irq_d = (lat_q == '0) && (lat_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_q <= '0;
      irq_q <= 1'b0;
    end else begin
      lat_q <= lat_d;
      irq_q <= irq_d;
    end
  end

  assign lat = lat_q;
  assign irq = irq_q;

endmodule

// File: rtl/vicii_sprite_mux.sv
// Sprite/background priority mux with registered colour output and the MM/MD
// collision latches. Collision logic is built only when VICII_COLLISION_EN is defined.
module vicii_sprite_mux
  import vicii_pkg::*;
#(
  parameter int NSPR = NSPR_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_stb,
  input  logic [NSPR-1:0]  spr_en,
  input  logic [NSPR*CW-1:0] spr_col,
  input  logic [CW-1:0]    bg_col,
  input  logic             bg_fg,
  input  logic             vis,
  input  logic [NSPR-1:0]  mdp,
  input  logic             rd_mm,
  input  logic             rd_md,
  output logic [CW-1:0]    pix_out,
  output logic [NSPR-1:0]  mm,
  output logic [NSPR-1:0]  md,
  output logic             irq_mm,
  output logic             irq_md
);

  logic [CW-1:0] pix_d, pix_q, pix_sel;

  // Scanning from the highest index down leaves the lowest enabled sprite as winner;
  // only that winner's mdp bit decides whether foreground graphics cover it.
  always_comb begin
    pix_sel = bg_col;
    for (int n = NSPR - 1; n >= 0; n--) begin
      if (spr_en[n]) begin
        pix_sel = (mdp[n] && bg_fg) ? bg_col : spr_col[n*CW +: CW];
      end
    end
    pix_d = pix_stb ? pix_sel : pix_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_q <= '0;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign pix_out = pix_q;

`ifdef VICII_COLLISION_EN
  logic            hit_ok, multi;
  logic [NSPR-1:0] mm_hit, md_hit;

  // x & (x-1) is nonzero exactly when two or more sprites are enabled.
  always_comb begin
    hit_ok = pix_stb && vis;
    multi  = |(spr_en & (spr_en - NSPR'(1)));
    mm_hit = (hit_ok && multi) ? spr_en : '0;
    md_hit = (hit_ok && bg_fg) ? spr_en : '0;
  end

  vicii_collision_latch #(.N(NSPR)) u_mm (
    .clk   (clk),
    .reset (reset),
    .rd    (rd_mm),
    .hit   (mm_hit),
    .lat   (mm),
    .irq   (irq_mm)
  );

  vicii_collision_latch #(.N(NSPR)) u_md (
    .clk   (clk),
    .reset (reset),
    .rd    (rd_md),
    .hit   (md_hit),
    .lat   (md),
    .irq   (irq_md)
  );
`else
  logic unused_coll;
  assign unused_coll = ^{vis, rd_mm, rd_md};
  assign mm     = '0;
  assign md     = '0;
  assign irq_mm = 1'b0;
  assign irq_md = 1'b0;
`endif

endmodule

// File: tb/tb_vicii_sprite_mux.sv
// Directed bench for vicii_sprite_mux; collision expectations follow VICII_COLLISION_EN.
module tb_vicii_sprite_mux;

`ifdef VICII_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pixStb = 1'b0;
  logic [7:0]  sprEn = '0;
  logic [31:0] sprCol = '0;
  logic [3:0]  bgCol = '0;
  logic        bgFg = 1'b0;
  logic        vis = 1'b0;
  logic [7:0]  mdp = '0;
  logic        rdMm = 1'b0;
  logic        rdMd = 1'b0;
  logic [3:0]  pixOut;
  logic [7:0]  mm, md;
  logic        irqMm, irqMd;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  vicii_sprite_mux dut (
    .clk     (clk),
    .reset   (reset),
    .pix_stb (pixStb),
    .spr_en  (sprEn),
    .spr_col (sprCol),
    .bg_col  (bgCol),
    .bg_fg   (bgFg),
    .vis     (vis),
    .mdp     (mdp),
    .rd_mm   (rdMm),
    .rd_md   (rdMd),
    .pix_out (pixOut),
    .mm      (mm),
    .md      (md),
    .irq_mm  (irqMm),
    .irq_md  (irqMd)
  );

  function automatic logic [31:0] ce(input logic [31:0] v);
    return COLL ? v : 32'h0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    testsRun++;
    if (obs !== expVal) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, expVal);
    end
  endtask

  // Drive one pixel's worth of inputs, take one clock edge, settle 1ns past it.
  task automatic applyStimulus(input logic [7:0] en, input logic [31:0] col, input logic [3:0] bg,
                               input logic fg, input logic v, input logic [7:0] pri,
                               input logic stb, input logic rmm, input logic rmd);
    sprEn  = en;
    sprCol = col;
    bgCol  = bg;
    bgFg   = fg;
    vis    = v;
    mdp    = pri;
    pixStb = stb;
    rdMm   = rmm;
    rdMd   = rmd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_pix", 32'(pixOut), 32'h0);
    checkOutput("rst_mm", 32'(mm), 32'h0);
    checkOutput("rst_md", 32'(md), 32'h0);
    checkOutput("rst_irq", 32'({irqMm, irqMd}), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Priority and hold behaviour, vis low so no collisions accumulate.
    applyStimulus(8'h06, 32'h0000_0520, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("prio_low_idx", 32'(pixOut), 32'h2);
    checkOutput("prio_no_mm_vis0", 32'(mm), 32'h0);
    applyStimulus(8'h00, 32'h0, 4'h9, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_stb0", 32'(pixOut), 32'h2);
    applyStimulus(8'h00, 32'h0, 4'h9, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("no_winner_bg", 32'(pixOut), 32'h9);
    applyStimulus(8'h01, 32'h0000_0007, 4'hE, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
    checkOutput("behind_fg", 32'(pixOut), 32'hE);
    applyStimulus(8'h01, 32'h0000_0007, 4'hE, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
    checkOutput("behind_bgpix", 32'(pixOut), 32'h7);
    applyStimulus(8'h03, 32'h0000_0037, 4'hE, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
    checkOutput("no_show_through", 32'(pixOut), 32'hE);
    applyStimulus(8'h02, 32'h0000_0037, 4'hE, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
    checkOutput("fg_front_sprite", 32'(pixOut), 32'h3);
    checkOutput("md_vis0", 32'(md), 32'h0);

    // Sprite-sprite collision held for three pixels: one IRQ pulse only.
    applyStimulus(8'h81, 32'h1000_0007, 4'h0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("mm_hit1", 32'(mm), ce(32'h81));
    checkOutput("irq_mm_1", 32'(irqMm), ce(32'h1));
    checkOutput("mm_pix", 32'(pixOut), 32'h7);
    applyStimulus(8'h81, 32'h1000_0007, 4'h0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("mm_hit2", 32'(mm), ce(32'h81));
    checkOutput("irq_mm_2", 32'(irqMm), 32'h0);
    applyStimulus(8'h81, 32'h1000_0007, 4'h0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("irq_mm_3", 32'(irqMm), 32'h0);

    // Read-clear without pix_stb; the collision still on screen is not sampled.
    applyStimulus(8'h81, 32'h1000_0007, 4'h0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("mm_clear_stb0", 32'(mm), 32'h0);
    checkOutput("mm_clear_irq", 32'(irqMm), 32'h0);
    applyStimulus(8'h81, 32'h1000_0007, 4'h0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("mm_rehit", 32'(mm), ce(32'h81));
    checkOutput("irq_mm_second", 32'(irqMm), ce(32'h1));

    // Read racing a hit while the latch is nonzero: new hit survives, no IRQ.
    applyStimulus(8'h00, 32'h0, 4'h0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h03, 32'h0, 4'h0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("mm_03", 32'(mm), ce(32'h03));
    checkOutput("irq_mm_03", 32'(irqMm), ce(32'h1));
    applyStimulus(8'h0C, 32'h0, 4'h0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    checkOutput("race_nz_mm", 32'(mm), ce(32'h0C));
    checkOutput("race_nz_irq", 32'(irqMm), 32'h0);

    // Read racing a hit while the latch is zero: IRQ fires.
    applyStimulus(8'h00, 32'h0, 4'h0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    checkOutput("race_pre_clear", 32'(mm), 32'h0);
    applyStimulus(8'h0C, 32'h0, 4'h0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    checkOutput("race_z_mm", 32'(mm), ce(32'h0C));
    checkOutput("race_z_irq", 32'(irqMm), ce(32'h1));

    // Sprite-data collision gated by vis.
    applyStimulus(8'h10, 32'h000A_0000, 4'h3, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("md_gated", 32'(md), 32'h0);
    checkOutput("irq_md_gated", 32'(irqMd), 32'h0);
    applyStimulus(8'h10, 32'h000A_0000, 4'h3, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("md_hit", 32'(md), ce(32'h10));
    checkOutput("irq_md_1", 32'(irqMd), ce(32'h1));
    checkOutput("md_pix", 32'(pixOut), 32'hA);
    applyStimulus(8'h10, 32'h000A_0000, 4'h3, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("irq_md_2", 32'(irqMd), 32'h0);
    checkOutput("mm_untouched", 32'(mm), ce(32'h0C));

    // Asynchronous reset between edges clears everything at once.
    #2 reset = 1'b0;
    #1;
    checkOutput("async_pix", 32'(pixOut), 32'h0);
    checkOutput("async_mm", 32'(mm), 32'h0);
    checkOutput("async_md", 32'(md), 32'h0);
    #2 reset = 1'b1;
    applyStimulus(8'h00, 32'h0, 4'h5, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("post_rst_pix", 32'(pixOut), 32'h5);
    checkOutput("post_rst_mm", 32'(mm), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/vicii_sprite_mux.md
Name: vicii_sprite_mux

Overview:
- Downstream consumer of the eight sprite units. It is fed by each unit's pixel_enable/pixel outputs and by the background graphics pixel.
- Resolves sprite/sprite and sprite/background priority and emits one registered output colour per pixel clock.
- Maintains the sprite-sprite (MM, $D01E) and sprite-data (MD, $D01F) collision latches. Both are clear-on-read and raise IRQ requests towards the interrupt logic.

Parameters:
NSPR, 8, number of sprite units merged (index 0 = highest priority)
CW, 4, colour width in bits

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
pix_stb  in  1  pixel clock enable; all state except read-clear advances only when high
spr_en  in  NSPR  per-sprite pixel_enable (bit n = sprite n)
spr_col  in  NSPR*CW  per-sprite colour, sprite n at [n*CW +: CW]
bg_col  in  CW  background/graphics colour for this pixel
bg_fg  in  1  graphics pixel is foreground (used for priority and MD collision)
vis  in  1  pixel inside display window; collisions detected only when high
mdp  in  NSPR  $D01B priority: bit n=1 puts sprite n behind foreground graphics
rd_mm  in  1  one-cycle strobe: CPU read of $D01E
rd_md  in  1  one-cycle strobe: CPU read of $D01F
pix_out  out  CW  resolved colour, registered
mm  out  NSPR  sprite-sprite collision latch
md  out  NSPR  sprite-data collision latch
irq_mm  out  1  one-cycle pulse: IMMC request
irq_md  out  1  one-cycle pulse: IMBC request

Behaviour:
- Reset (asynchronous, reset low): pix_out=0, mm=0, md=0, irq_mm=0, irq_md=0.
- Priority is combinational. The winner is the lowest index n with spr_en[n]=1.
  - No winner: colour is bg_col.
  - Winner with mdp[n]=1 and bg_fg=1: colour is bg_col.
  - Otherwise: colour is winner's spr_col.
  - Only the winner's mdp bit is consulted. A lower-priority sprite never shows through a winner that is hidden behind foreground.
- pix_out is registered on clk when pix_stb=1, so latency is 1 clk from the sampled inputs. It holds its value while pix_stb=0.
- Collision detect, evaluated at pix_stb=1 and vis=1:
  - mm_hit = spr_en when popcount(spr_en) >= 2, else 0.
  - md_hit = spr_en when bg_fg=1, else 0.
- Latch update:
  - mm_next = (rd_mm ? 0 : mm) | mm_hit.
  - md_next = (rd_md ? 0 : md) | md_hit.
  - Read-clear is honoured on any clk regardless of pix_stb.
  - A hit in the same cycle as a read survives, so no collision is lost.
  - Reads see the pre-clear value, because mm/md are registered outputs.
- IRQ rule: irq_mm pulses high for exactly one clk when mm transitions 0 -> nonzero. Further hits while mm is nonzero give no pulse. The next pulse needs a clear first. irq_md follows the same rule on md.
- Read with simultaneous hit while the latch was nonzero: the latch goes nonzero -> nonzero and no IRQ fires.
- Read with simultaneous hit while the latch was zero: IRQ fires.
- vis=0: no hits are generated. Priority and output are unaffected.
- Reset mid-frame clears the latches immediately. The first pix_stb after release resumes normally.

Optional Feature:
- Macro: VICII_COLLISION_EN.
- Defined: collision latches and IRQ logic as specified above.
- Undefined: mm, md, irq_mm and irq_md are tied to 0 and no collision flops are synthesised. Priority and pix_out are unchanged.

Decomposition:
- Shared package vicii_pkg holds:
  - NSPR_DEF=8 and CW_DEF=4.
  - Register offsets REG_MM=6'h1E, REG_MD=6'h1F, REG_MDP=6'h1B.
  - A colour typedef of CW bits.
- Sub-module vicii_collision_latch holds the NSPR-bit latch, clear-on-read and 0->nonzero IRQ pulse. It is instantiated twice, for MM and MD.
- Priority encoding stays inline.

Test Plan:
- Priority: spr_en=8'b0000_0110, spr_col[1]=4'h2, spr_col[2]=4'h5, mdp=0, pix_stb=1 -> pix_out=4'h2 one clk later.
- Behind-foreground: spr_en=8'h01, mdp=8'h01, bg_fg=1, bg_col=4'hE, spr_col[0]=4'h7 -> pix_out=4'hE. With bg_fg=0 -> pix_out=4'h7.
- MM collision and IRQ: spr_en=8'h81, vis=1 for 3 pix_stb -> mm=8'h81, irq_mm high exactly once. Then rd_mm -> mm=0 next clk. Repeat hit -> second irq_mm pulse.
- Read/hit race: mm=8'h03, rd_mm coincides with hit spr_en=8'h0C -> mm=8'h0C, no irq_mm.
- MD with vis gating: spr_en=8'h10, bg_fg=1, vis=0 -> md=0. Same stimulus with vis=1 -> md=8'h10, irq_md pulse.
- Async reset: assert reset low between clk edges with mm/md/pix_out nonzero -> all outputs 0 immediately, before the next edge.
